// File: rtl/switches_debounce_pkg.sv
// switches_debounce_pkg: shared state type, default sizes and counter-width helper
package switches_debounce_pkg;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam int N_BITS_DEF = 18;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction
endpackage

// File: rtl/switches_debounce_if.sv
// switches_debounce_if: switch pins in, debounced levels/strobes/edge flags out
interface switches_debounce_if import switches_debounce_pkg::*; #(parameter int N_BITS = N_BITS_DEF);
    logic [N_BITS-1:0] sw_raw, sw_out, sw_rise, sw_fall, edge_clr, edge_capture;
    logic sw_valid, irq;
    modport master (output sw_raw, edge_clr, input sw_out, sw_valid, sw_rise, sw_fall, edge_capture, irq);
    modport slave (input sw_raw, edge_clr, output sw_out, sw_valid, sw_rise, sw_fall, edge_capture, irq);
endinterface

// File: rtl/switches_debounce_bit.sv
// switches_debounce_bit: synchroniser, stability counter, level and rise/fall strobes for one pin
module switches_debounce_bit import switches_debounce_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic load,
    input  logic run,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic s, hit;
    assign s = sync[SYNC_STAGES-1];
    assign hit = run && s != level && cnt == CNT_MAX;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            cnt <= (!run || s == level || hit) ? '0 : cnt + 1'b1;
            level <= (load || hit) ? s : level;
            rise <= hit && s;
            fall <= hit && !s;
        end
    end
endmodule

// File: rtl/switches_debounce.sv
// switches_debounce: debounced DE2 slide switches; SWITCHES_DEBOUNCE_EDGE_CAPTURE_EN adds sticky edge flags and irq
module switches_debounce import switches_debounce_pkg::*; #(
    parameter int N_BITS = N_BITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input logic clk,
    input logic reset_n,
    switches_debounce_if.slave bus
);
    state_t state, state_nx;
    logic [2:0] fill;
    logic load;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            fill <= '0;
        end else begin
            state <= state_nx;
            fill <= (state == ST_INIT) ? fill + 1'b1 : fill;
        end
    end
    // the synchroniser is full after SYNC_STAGES edges; the next edge loads it as-is
    always_comb begin
        load = state == ST_INIT && fill == 3'(SYNC_STAGES);
        state_nx = load ? ST_RUN : state;
    end
    assign bus.sw_valid = state == ST_RUN;
    for (genvar g = 0; g < N_BITS; g++) begin : g_bit
        switches_debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk(clk),
            .reset_n(reset_n),
            .raw(bus.sw_raw[g]),
            .load(load),
            .run(state == ST_RUN),
            .level(bus.sw_out[g]),
            .rise(bus.sw_rise[g]),
            .fall(bus.sw_fall[g])
        );
    end
`ifdef SWITCHES_DEBOUNCE_EDGE_CAPTURE_EN
    logic [N_BITS-1:0] cap;
    logic irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap <= '0;
            irq_q <= 1'b0;
        end else begin
            cap <= (cap & ~bus.edge_clr) | bus.sw_rise | bus.sw_fall;
            irq_q <= |cap;
        end
    end
    assign bus.edge_capture = cap;
    assign bus.irq = irq_q;
`else
    logic unused_clr;
    assign unused_clr = ^bus.edge_clr;
    assign bus.edge_capture = '0;
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_switches_debounce.sv
// tb_switches_debounce: random and directed stimulus against a sample-history window model
module tb_switches_debounce;
    import switches_debounce_pkg::*;
    localparam int N = 18;
    localparam int SYNC = 2;
    localparam int DB = 4;
    localparam int HMAX = 16384;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    switches_debounce_if #(.N_BITS(N)) bus();
    switches_debounce #(.N_BITS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    int total = 0;
    int bad = 0;
    int r;
    logic [N-1:0] samp [HMAX];
    logic [N-1:0] sh [HMAX];
    logic [N-1:0] m_out, m_rise, m_fall, m_cap, s_now, nr, nf;
    logic m_valid, m_irq, stable, found;
    int rise_cnt [N];
    int fall_cnt [N];
    logic [N-1:0] hold;
    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic clear_counts();
        for (int b = 0; b < N; b++) begin
            rise_cnt[b] = 0;
            fall_cnt[b] = 0;
        end
    endtask
    // model: s seen at edge r is the pin sampled SYNC edges earlier; a bit flips when the last DB RUN-edge views all differ
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            r = 0;
            m_out = '0; m_rise = '0; m_fall = '0; m_cap = '0;
            m_valid = 1'b0; m_irq = 1'b0;
        end else begin
`ifdef SWITCHES_DEBOUNCE_EDGE_CAPTURE_EN
            m_irq = |m_cap;
            m_cap = (m_cap & ~bus.edge_clr) | m_rise | m_fall;
`endif
            r = r + 1;
            if (r >= HMAX) begin
                $display("FAIL model_history r=%0d required<%0d", r, HMAX);
                $fatal(1, "history overflow");
            end
            samp[r] = bus.sw_raw;
            s_now = (r > SYNC) ? samp[r-SYNC] : '0;
            sh[r] = s_now;
            nr = '0;
            nf = '0;
            if (r == SYNC + 1) begin
                m_out = s_now;
                m_valid = 1'b1;
            end else if (r - DB + 1 >= SYNC + 2) begin
                for (int b = 0; b < N; b++) begin
                    stable = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (sh[r-j][b] == m_out[b]) stable = 1'b0;
                    if (stable) begin
                        nr[b] = s_now[b];
                        nf[b] = !s_now[b];
                        m_out[b] = s_now[b];
                    end
                end
            end
            m_rise = nr;
            m_fall = nf;
        end
    end
    initial forever begin
        @(negedge clk);
        chk("sw_out", bus.sw_out, m_out);
        chk("sw_valid", N'(bus.sw_valid), N'(m_valid));
        chk("sw_rise", bus.sw_rise, m_rise);
        chk("sw_fall", bus.sw_fall, m_fall);
        chk("edge_capture", bus.edge_capture, m_cap);
        chk("irq", N'(bus.irq), N'(m_irq));
        for (int b = 0; b < N; b++) begin
            if (bus.sw_rise[b]) rise_cnt[b]++;
            if (bus.sw_fall[b]) fall_cnt[b]++;
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end
    initial begin
        clear_counts();
        bus.sw_raw = 18'h2A5A5;
        bus.edge_clr = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("init_valid_early", N'(bus.sw_valid), '0);
        @(negedge clk);
        chk("init_valid", N'(bus.sw_valid), N'(1));
        chk("init_load", bus.sw_out, 18'h2A5A5);
        chk("init_no_pulse", bus.sw_rise | bus.sw_fall, '0);
        bus.sw_raw[0] = 1'b0;
        bus.sw_raw[5] = 1'b0;
        repeat (12) @(negedge clk);
        clear_counts();
        bus.sw_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("step_before", N'(bus.sw_out[0]), '0);
        @(negedge clk);
        chk("step_after", N'(bus.sw_out[0]), N'(1));
        chk("step_rise", N'(bus.sw_rise[0]), N'(1));
        @(negedge clk);
        chk("step_rise_once", N'(bus.sw_rise[0]), '0);
        repeat (5) @(negedge clk);
        chk("step_rise_count", N'(rise_cnt[0]), N'(1));
        bus.sw_raw[5] = 1'b1;
        repeat (3) @(negedge clk);
        bus.sw_raw[5] = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_level", N'(bus.sw_out[5]), '0);
        chk("glitch_pulses", N'(rise_cnt[5] + fall_cnt[5]), '0);
        repeat (5) begin
            bus.sw_raw[17] = 1'b0;
            repeat (2) @(negedge clk);
            bus.sw_raw[17] = 1'b1;
            repeat (2) @(negedge clk);
        end
        chk("bounce_held", N'(bus.sw_out[17]), N'(1));
        chk("bounce_no_fall", N'(fall_cnt[17]), '0);
        bus.sw_raw[17] = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_settled", N'(bus.sw_out[17]), '0);
        chk("bounce_one_fall", N'(fall_cnt[17]), N'(1));
        bus.sw_raw = bus.sw_raw ^ 18'h00208;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sw_rise[3]) begin
                found = 1'b1;
                break;
            end
        end
        chk("multi_found", N'(found), N'(1));
        chk("multi_coincide", bus.sw_rise & 18'h00208, 18'h00208);
        repeat (3) @(negedge clk);
        clear_counts();
        bus.sw_raw[12] = ~bus.sw_raw[12];
        hold = bus.sw_raw;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out", bus.sw_out, '0);
        chk("rst_valid", N'(bus.sw_valid), '0);
        chk("rst_pulses", bus.sw_rise | bus.sw_fall, '0);
        chk("rst_capture", bus.edge_capture, '0);
        chk("rst_irq", N'(bus.irq), '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reinit_valid_early", N'(bus.sw_valid), '0);
        @(negedge clk);
        chk("reinit_valid", N'(bus.sw_valid), N'(1));
        chk("reinit_load", bus.sw_out, hold);
        repeat (3) @(negedge clk);
        chk("reinit_no_pulse", N'(rise_cnt[12] + fall_cnt[12]), '0);
`ifdef SWITCHES_DEBOUNCE_EDGE_CAPTURE_EN
        bus.sw_raw[2] = 1'b0;
        repeat (10) @(negedge clk);
        bus.edge_clr = '1;
        @(negedge clk);
        bus.edge_clr = '0;
        @(negedge clk);
        chk("cap_cleared", bus.edge_capture, '0);
        bus.sw_raw[2] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sw_rise[2]) begin
                found = 1'b1;
                break;
            end
        end
        chk("cap_rise_found", N'(found), N'(1));
        @(negedge clk);
        chk("cap_set", bus.edge_capture, 18'h00004);
        chk("cap_irq_lag", N'(bus.irq), '0);
        @(negedge clk);
        chk("cap_irq", N'(bus.irq), N'(1));
        bus.edge_clr = 18'h00004;
        @(negedge clk);
        bus.edge_clr = '0;
        chk("cap_clr", bus.edge_capture, '0);
        chk("cap_irq_hold", N'(bus.irq), N'(1));
        @(negedge clk);
        chk("cap_irq_drop", N'(bus.irq), '0);
        bus.edge_clr = 18'h00004;
        bus.sw_raw[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sw_fall[2]) begin
                found = 1'b1;
                break;
            end
        end
        chk("cap_fall_found", N'(found), N'(1));
        @(negedge clk);
        bus.edge_clr = '0;
        chk("cap_set_wins", bus.edge_capture, 18'h00004);
        bus.edge_clr = 18'h00004;
        @(negedge clk);
        bus.edge_clr = '0;
`endif
        for (int i = 0; i < 300; i++) begin
            bus.sw_raw = ($urandom_range(0, 9) == 0) ? N'($urandom) : bus.sw_raw ^ N'($urandom & $urandom & $urandom);
            bus.edge_clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        bus.edge_clr = '0;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
